ysyx_22041071_axi_r_slave: RTL and testbench
============================================

// Module: ysyx_22041071_axi_r_slave
// PURPOSE
//  AXI4 read-channel responder (AR accept, R return) fronting a 1-cycle-latency synchronous SRAM.
//  Serves the core's AXI read master in simulation/SoC-less builds; one outstanding burst.
//  A 2-entry output buffer gives full throughput and absorbs rready backpressure.
// PARAMETERS
//  ID_W       4             AXI ID width
//  ADDR_W     64            AXI address width
//  DATA_W     64            AXI data width (8 bytes/beat)
//  LEN_W      8             arlen width (bursts of 1..256 beats)
//  MEM_BASE   64'h8000_0000 first byte address decoded to SRAM
//  MEM_SIZE   64'h0800_0000 SRAM size in bytes
//  LFSR_SEED  8'hA5         stall LFSR seed (used only with the macro below)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       synchronous, active-low reset
//  s_arvalid    in   1       AR valid
//  s_arready    out  1       AR ready
//  s_arid       in   ID_W    AR id
//  s_araddr     in   ADDR_W  AR byte address
//  s_arlen      in   LEN_W   beats-1
//  s_arsize     in   3       bytes/beat = 1<<arsize
//  s_arburst    in   2       00 FIXED, 01 INCR, 10/11 unsupported
//  s_rvalid     out  1       R valid
//  s_rready     in   1       R ready
//  s_rid        out  ID_W    latched arid
//  s_rdata      out  DATA_W  full-width word containing the beat address
//  s_rresp      out  2       00 OKAY, 10 SLVERR, 11 DECERR
//  s_rlast      out  1       final beat
//  s_ruser      out  1       tied 0
//  mem_ren      out  1       SRAM read strobe
//  mem_raddr    out  ADDR_W-3 word index = (beat_addr-MEM_BASE)>>3
//  mem_rdata    in   DATA_W  valid the cycle after mem_ren
// BEHAVIOUR
//  Reset: state IDLE, FIFO/in-flight flushed; s_rvalid/s_rlast/mem_ren 0, s_rdata/s_rresp/s_rid 0; s_arready 1 after reset.
//  FSM: IDLE -(AR handshake)-> ISSUE -(last beat issued)-> DRAIN -(rlast handshake)-> IDLE.
//  s_arready = (state==IDLE), no comb path from arvalid. Handshake latches id, addr, len, size, burst; beats_left=arlen+1.
//  Beat addr: INCR next = addr + (1<<size); FIXED unchanged. Word select = addr[ADDR_W-1:3]; no data shifting.
//  Issue rule (ISSUE only): one beat/cycle when fifo_cnt + inflight - pop <= 1, pop = s_rvalid&s_rready.
//  OKAY beat: mem_ren=1; next cycle {mem_rdata,00,last} pushed into FIFO.
//  Error beats: no mem_ren, {0,resp,last} pushed same 1-cycle delay as data beats.
//   DECERR when beat addr outside [MEM_BASE, MEM_BASE+MEM_SIZE) (checked per beat).
//   SLVERR for all beats when arburst in {10,11} or arsize>3; error takes precedence over DECERR.
//  Latency: AR handshake cycle T -> mem_ren T+1 -> s_rvalid T+2; rready held 1 gives 1 beat/cycle, no bubbles.
//  s_rvalid = FIFO non-empty; head payload stable while s_rvalid & !s_rready (AXI rule).
//  s_rlast only on beat arlen; after its handshake state=IDLE, s_arready 1 next cycle.
//  FIFO never overflows: push only for an issued beat, and issue rule reserves the slot.
//  INCR address wraps mod 2^ADDR_W; wrapped beats fall outside the window -> DECERR.
//  Reset mid-burst: everything flushed next edge, partial burst abandoned, no stray R beats.
// CONFIGURATION
//  YSYX_22041071_AXI_RS_STALL_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded LFSR_SEED,
//   steps every cycle) blocks issue whenever lfsr[0]==1 and holds s_arready 0 in IDLE when lfsr[1]==1;
//   exercises master backpressure tolerance. Not defined: no LFSR, behaviour exactly as above.
// TESTING
//  1 araddr 0x8000_0008 len0 size3, word1=0x1122334455667788, rready=1 -> rvalid at T+2, that data, rresp 00, rlast 1.
//  2 INCR len3 @0x8000_0000, rready=1 -> 4 back-to-back beats words0..3, rlast only on beat 4, arready 1 after.
//  3 Same burst, rready toggling 1,0,1,0 (also rerun with STALL_EN) -> 4 beats in order, none lost/duplicated, payload stable.
//  4 araddr 0x1000_0000 len1 -> 2 beats rresp 11 rdata 0, rlast on 2nd, mem_ren never asserted.
//  5 araddr MEM_BASE+MEM_SIZE-8 len1 INCR -> beat0 OKAY with last word, beat1 DECERR data 0 rlast 1; arburst 10 len0 -> 1 beat SLVERR.
//  6 reset_n low after 2 of 8 beats -> next cycle rvalid 0, arready 1; new len0 read returns correct word, rid matches.

Source files
------------

// File: rtl/ysyx_22041071_axi_r_slave.sv
// AXI4 read-channel responder (AR accept, R return) in front of a 1-cycle synchronous SRAM; one burst outstanding.
// Latency: AR handshake in cycle T -> mem_ren in T+1 -> s_rvalid in T+2; one beat per cycle while s_rready is held high.
// Backpressure: a 2-entry R buffer absorbs s_rready stalls; issue pauses so that buffer and in-flight read never exceed 2 entries.
//
// Ports: clk/reset_n (synchronous, active-low); AR slave channel s_ar*; R slave channel s_r* (s_ruser tied 0);
//        SRAM read port mem_ren/mem_raddr (word index relative to MEM_BASE), mem_rdata valid the cycle after mem_ren.
// Build option: define YSYX_22041071_AXI_RS_STALL_EN to add an LFSR that randomly blocks issue and AR acceptance.

module ysyx_22041071_axi_rs_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   cnt
);
    // Two-entry FIFO, synchronous flush; caller guarantees no push when full and no pop when empty.
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
endmodule

module ysyx_22041071_axi_r_slave #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                LEN_W     = 8,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = 64'h0800_0000,
    parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [LEN_W-1:0]  s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_ruser,
    output logic              mem_ren,
    output logic [ADDR_W-4:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    // An all-zero seed would lock the stall LFSR permanently.
    if (LFSR_SEED == 8'h00) begin : g_seed_check
        $error("LFSR_SEED must be non-zero");
    end

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [LEN_W:0]    beats_left_q;

    logic              inflight_vld_q;
    logic [1:0]        inflight_resp_q;
    logic              inflight_last_q;

    logic              stall_issue;
    logic              stall_ar;

`ifdef YSYX_22041071_AXI_RS_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign stall_issue = lfsr_q[0];
    assign stall_ar    = lfsr_q[1];
`else
    assign stall_issue = 1'b0;
    assign stall_ar    = 1'b0;
`endif

    // Per-beat response classification on the current beat address.
    logic              beat_slverr;
    logic              beat_decerr;
    logic [ADDR_W-1:0] beat_off;
    logic [1:0]        beat_resp;
    logic              beat_last;

    assign beat_off    = addr_q - MEM_BASE;
    assign beat_slverr = burst_q[1] | (size_q > 3'd3);
    // Unsigned offset catches both below-base and past-end addresses.
    assign beat_decerr = (beat_off >= MEM_SIZE);
    assign beat_resp   = beat_slverr ? RESP_SLVERR : (beat_decerr ? RESP_DECERR : RESP_OKAY);
    assign beat_last   = (beats_left_q == {{LEN_W{1'b0}}, 1'b1});

    // R buffer: the in-flight beat lands this cycle and falls straight through when the buffer is empty.
    r_beat_t     push_dat;
    r_beat_t     fifo_head;
    r_beat_t     head;
    logic [1:0]  fifo_cnt;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        pop;
    logic [2:0]  occupancy;
    logic        issue;

    assign push_dat.data = (inflight_resp_q == RESP_OKAY) ? mem_rdata : '0;
    assign push_dat.resp = inflight_resp_q;
    assign push_dat.last = inflight_last_q;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign s_rvalid   = !fifo_empty || inflight_vld_q;
    assign head       = fifo_empty ? push_dat : fifo_head;
    assign pop        = s_rvalid && s_rready;
    assign fifo_push  = inflight_vld_q && !(fifo_empty && s_rready);
    assign fifo_pop   = !fifo_empty && s_rready;

    ysyx_22041071_axi_rs_fifo #(
        .W ($bits(r_beat_t))
    ) u_r_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .cnt      (fifo_cnt)
    );

    // Entries held after this edge = fifo_cnt + inflight - pop; a new issue needs one spare slot behind them.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_vld_q} - {2'b00, pop};
    assign issue     = (state_q == ISSUE) && (occupancy <= 3'd1) && !stall_issue;

    assign mem_ren   = issue && (beat_resp == RESP_OKAY);
    // MEM_BASE is word aligned, so subtracting word indices equals (addr - MEM_BASE) >> 3.
    assign mem_raddr = addr_q[ADDR_W-1:3] - MEM_BASE[ADDR_W-1:3];

    assign s_arready = (state_q == IDLE) && !stall_ar;

    assign s_rdata = s_rvalid ? head.data : '0;
    assign s_rresp = s_rvalid ? head.resp : 2'b00;
    assign s_rlast = s_rvalid ? head.last : 1'b0;
    assign s_rid   = s_rvalid ? id_q : '0;
    assign s_ruser = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_arvalid && s_arready) state_d = ISSUE;
            ISSUE:   if (issue && beat_last)     state_d = DRAIN;
            DRAIN:   if (pop && head.last)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_q            <= '0;
            addr_q          <= '0;
            size_q          <= 3'd0;
            burst_q         <= 2'b00;
            beats_left_q    <= '0;
            inflight_vld_q  <= 1'b0;
            inflight_resp_q <= 2'b00;
            inflight_last_q <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) begin
                id_q         <= s_arid;
                addr_q       <= s_araddr;
                size_q       <= s_arsize;
                burst_q      <= s_arburst;
                beats_left_q <= {1'b0, s_arlen} + {{LEN_W{1'b0}}, 1'b1};
            end else if (issue) begin
                beats_left_q <= beats_left_q - {{LEN_W{1'b0}}, 1'b1};
                // INCR wraps naturally at 2^ADDR_W; wrapped beats then decode as DECERR.
                if (burst_q == BURST_INCR) addr_q <= addr_q + (ADDR_W'(1) << size_q);
            end
            inflight_vld_q  <= issue;
            inflight_resp_q <= beat_resp;
            inflight_last_q <= beat_last;
        end
    end
endmodule

// File: tb/tb_ysyx_22041071_axi_r_slave.sv
// Randomized and directed bench for the AXI read responder against a queue-based burst model.
// Latency: checks AR-to-mem_ren and AR-to-rvalid in the default build.
// Backpressure: drives s_rready high, toggling or random and checks held R payload stability.

module tb_ysyx_22041071_axi_r_slave;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'h0800_0000;

    logic        clk;
    logic        reset_n;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_arid;
    logic [63:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid;
    logic        s_rready;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_ruser;
    logic        mem_ren;
    logic [60:0] mem_raddr;
    logic [63:0] mem_rdata;

    ysyx_22041071_axi_r_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_ruser   (s_ruser),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int beats_seen = 0;
    int ar_hs_cyc = 0;
    int first_ren_cyc = -1;
    int first_rvalid_cyc = -1;
    int last_beat_cyc = 0;
    logic [63:0] last_rdata = '0;
    logic want_first = 1'b0;
    int rr_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM contents: word 1 is a fixed pattern, the rest a hash of the index.
    function automatic logic [63:0] word_at(input logic [63:0] idx);
        logic [31:0] lo;
        lo = idx[31:0];
        if (idx == 64'd1) return 64'h1122_3344_5566_7788;
        return {lo * 32'h9E37_79B1, ~lo};
    endfunction

    // Junk on idle cycles so error beats must zero their data themselves.
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= word_at({3'b000, mem_raddr});
            ren_cnt   <= ren_cnt + 1;
        end else begin
            mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    // Reference: expand one AR into its beats straight from the AXI rules.
    task automatic model_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                               input int size, input int burst);
        logic [63:0] a;
        beat_t b;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            b.id   = id;
            b.last = (i == len);
            if (burst >= 2 || size > 3)                b.resp = 2'b10;
            else if (a < BASE || a >= BASE + SIZE)     b.resp = 2'b11;
            else                                       b.resp = 2'b00;
            b.data = (b.resp == 2'b00) ? word_at((a - BASE) >> 3) : 64'd0;
            exp_q.push_back(b);
            if (burst == 1) a = a + (64'd1 << size);
        end
    endtask

    initial begin
        s_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       s_rready = 1'b1;
                1:       s_rready = ~s_rready;
                default: s_rready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // R monitor: scoreboard compare on every handshake plus hold-stability while stalled.
    initial begin
        logic held;
        beat_t prev;
        beat_t e;
        held = 1'b0;
        prev = '{default: '0};
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (want_first && mem_ren && first_ren_cyc < 0) first_ren_cyc = cyc;
                if (want_first && s_rvalid && first_rvalid_cyc < 0) first_rvalid_cyc = cyc;
                if (held) begin
                    chk("hold_vld", s_rvalid, 1);
                    chk("hold_dat", s_rdata, prev.data);
                    chk("hold_meta", {s_rid, s_rresp, s_rlast}, {prev.id, prev.resp, prev.last});
                end
                if (s_rvalid && s_rready) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", s_rdata, e.data);
                        chk("rresp", s_rresp, e.resp);
                        chk("rlast", s_rlast, e.last);
                        chk("rid", s_rid, e.id);
                        chk("ruser", s_ruser, 0);
                    end
                    beats_seen++;
                    last_beat_cyc = cyc;
                    last_rdata    = s_rdata;
                end
                held      = s_rvalid && !s_rready;
                prev.data = s_rdata;
                prev.resp = s_rresp;
                prev.last = s_rlast;
                prev.id   = s_rid;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input int len,
                           input int size, input int burst);
        int n;
        model_burst(id, addr, len, size, burst);
        @(posedge clk);
        #1;
        s_arvalid = 1'b1;
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = 8'(len);
        s_arsize  = 3'(size);
        s_arburst = 2'(burst);
        n = 0;
        forever begin
            @(negedge clk);
            if (s_arready) break;
            n++;
            if (n > 300) begin
                chk("ar_timeout", 0, 1);
                break;
            end
        end
        ar_hs_cyc        = cyc;
        first_ren_cyc    = -1;
        first_rvalid_cyc = -1;
        want_first       = 1'b1;
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        #1;
        chk("rvalid_idle", s_rvalid, 0);
`ifndef YSYX_22041071_AXI_RS_STALL_EN
        chk("arready_after", s_arready, 1);
`endif
        want_first = 1'b0;
    endtask

    initial begin
        int b0;
        int r0;
        int n;
        logic [63:0] addr;
        int len, size, burst, r;

        reset_n   = 1'b0;
        s_arvalid = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_arready", s_arready, 1);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_payload", {s_rid, s_rresp, s_rlast, s_ruser}, 0);
        chk("rst_rdata", s_rdata, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single beat from word 1, with latency.
        rr_mode = 0;
        send_ar(4'h3, BASE + 64'h8, 0, 3, 1);
        wait_done();
        chk("t1_data", last_rdata, 64'h1122_3344_5566_7788);
`ifndef YSYX_22041071_AXI_RS_STALL_EN
        chk("t1_lat_ren", 32'(first_ren_cyc - ar_hs_cyc), 1);
        chk("t1_lat_rvalid", 32'(first_rvalid_cyc - ar_hs_cyc), 2);
`endif

        // Four-beat INCR burst, back to back.
        b0 = beats_seen;
        send_ar(4'h7, BASE, 3, 3, 1);
        wait_done();
        chk("t2_beats", beats_seen - b0, 4);
`ifndef YSYX_22041071_AXI_RS_STALL_EN
        chk("t2_b2b", 32'(last_beat_cyc - first_rvalid_cyc), 3);
`endif

        // Same burst with rready toggling.
        rr_mode = 1;
        b0 = beats_seen;
        send_ar(4'hA, BASE, 3, 3, 1);
        wait_done();
        chk("t3_beats", beats_seen - b0, 4);

        // Out-of-window: DECERR and no SRAM access.
        rr_mode = 0;
        r0 = ren_cnt;
        send_ar(4'h1, 64'h1000_0000, 1, 3, 1);
        wait_done();
        chk("t4_no_ren", ren_cnt - r0, 0);

        // Crossing the window end, unsupported burst, wrap past 2^64.
        send_ar(4'h2, BASE + SIZE - 64'h8, 1, 3, 1);
        wait_done();
        r0 = ren_cnt;
        send_ar(4'h4, BASE, 0, 3, 2);
        wait_done();
        chk("t5_slverr_no_ren", ren_cnt - r0, 0);
        send_ar(4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 2, 3, 1);
        wait_done();

        // Reset after 2 of 8 beats, then a fresh read.
        b0 = beats_seen;
        send_ar(4'h6, BASE + 64'h100, 7, 3, 1);
        n = 0;
        while (beats_seen - b0 < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_two_beats", (beats_seen - b0 >= 2), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_rvalid", s_rvalid, 0);
        chk("t6_arready", s_arready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_ar(4'h9, BASE + 64'h40, 0, 3, 1);
        wait_done();

        // Long burst under random backpressure, then random traffic.
        rr_mode = 2;
        send_ar(4'hC, BASE + 64'h1000, 255, 3, 1);
        wait_done();
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      addr = BASE + (64'($urandom_range(0, 4095)) << 3) + 64'($urandom_range(0, 7));
            else if (r == 7) addr = BASE + SIZE - 64'(8 * $urandom_range(1, 4));
            else if (r == 8) addr = {$urandom, $urandom};
            else             addr = BASE - 64'h8;
            len  = $urandom_range(0, 15);
            r    = $urandom_range(0, 9);
            size = (r < 9) ? (r % 4) : $urandom_range(4, 7);
            r    = $urandom_range(0, 9);
            burst = (r <= 5) ? 1 : ((r <= 7) ? 0 : $urandom_range(2, 3));
            send_ar(4'($urandom_range(0, 15)), addr, len, size, burst);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
